// File: rtl/mmio_timer_if.sv
// mmio_timer_if: core <-> timer peripheral data-memory bus.
//   addr      byte address from the core
//   wdata     store data
//   mem_read  load strobe
//   mem_write store strobe
//   hit       peripheral window decode (combinational, from the slave)
//   rdata     read data (combinational, from the slave, zero when not selected)
interface mmio_timer_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_read;
  logic        mem_write;
  logic        hit;
  logic [31:0] rdata;

  modport master (output addr, wdata, mem_read, mem_write, input hit, rdata);
  modport slave  (input addr, wdata, mem_read, mem_write, output hit, rdata);
endinterface

// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped reloadable up-counter with interrupt request.
//
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous active-high reset
//   bus    mmio_timer_if.slave (addr, wdata, mem_read, mem_write -> hit, rdata)
//   irq    registered interrupt request (IE & IF, one cycle late)
//
// Register map (word offsets, addr[1:0] ignored):
//   0x00 TH reload, 0x04 TL counter, 0x08 TCON {IF,IE,EN}, 0x14 SYSTICK (RO).
//
// Build option: define MMIO_TIMER_SYSTICK_EN to add the free-running SYSTICK
// cycle counter; without it offset 0x14 reads 0.
module mmio_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int          PRESCALE  = 1
) (
  input  logic         clk,
  input  logic         reset,
  mmio_timer_if.slave  bus,
  output logic         irq
);

  localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);

  logic [31:0] r_th;
  logic [31:0] r_tl;
  logic        r_en;
  logic        r_ie;
  logic        r_if;
  logic [15:0] r_pre;
  logic        r_irq;

  logic        w_hit;
  logic [2:0]  w_off;
  logic        w_wr;
  logic        w_tick;
  logic        w_ovf;
  logic        w_set_if;
  logic [31:0] w_systick;
  logic [31:0] w_rsel;
  logic        w_unused;

  assign w_hit    = (bus.addr[31:5] == BASE_ADDR[31:5]);
  assign w_off    = bus.addr[4:2];
  assign w_wr     = bus.mem_write & w_hit;
  assign w_tick   = r_en & (r_pre == PRE_MAX);
  assign w_ovf    = w_tick & (&r_tl);
  assign w_set_if = w_ovf & r_ie;
  assign w_unused = &{1'b0, bus.addr[1:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_th  <= '0;
      r_tl  <= '0;
      r_en  <= 1'b0;
      r_ie  <= 1'b0;
      r_if  <= 1'b0;
      r_pre <= '0;
      r_irq <= 1'b0;
    end else begin
      // prescaler freezes (keeps its phase) while disabled
      if (r_en)
        r_pre <= w_tick ? '0 : r_pre + 16'd1;

      // TH reload on overflow below uses r_th before this write lands
      if (w_wr && w_off == 3'd0)
        r_th <= bus.wdata;

      // software write beats tick/overflow
      if (w_wr && w_off == 3'd1)
        r_tl <= bus.wdata;
      else if (w_ovf)
        r_tl <= r_th;
      else if (w_tick)
        r_tl <= r_tl + 32'd1;

      // an overflow-driven IF set is never lost to a same-cycle clear
      if (w_wr && w_off == 3'd2) begin
        r_en <= bus.wdata[0];
        r_ie <= bus.wdata[1];
        r_if <= bus.wdata[2] | w_set_if;
      end else if (w_set_if) begin
        r_if <= 1'b1;
      end

      r_irq <= r_ie & r_if;
    end
  end

`ifdef MMIO_TIMER_SYSTICK_EN
  logic [31:0] r_systick;

  always_ff @(posedge clk) begin
    if (reset) r_systick <= '0;
    else       r_systick <= r_systick + 32'd1;
  end

  assign w_systick = r_systick;
`else
  assign w_systick = '0;
`endif

  always_comb begin
    w_rsel = '0;
    case (w_off)
      3'd0:    w_rsel = r_th;
      3'd1:    w_rsel = r_tl;
      3'd2:    w_rsel = {29'd0, r_if, r_ie, r_en};
      3'd5:    w_rsel = w_systick;
      default: w_rsel = '0;
    endcase
  end

  // zero-latency read: valid in the same cycle as mem_read
  assign bus.hit   = w_hit;
  assign bus.rdata = (bus.mem_read && w_hit) ? w_rsel : 32'h0;
  assign irq       = r_irq;

endmodule

// File: tb/tb_mmio_timer.sv
// Scoreboard bench for mmio_timer: one instance with PRESCALE=1, one with
// PRESCALE=4. Read stimulus pushes the expected {rdata, hit, irq}; a negedge
// monitor pops and compares whenever a read strobe is on either bus.
module tb_mmio_timer;

  localparam logic [31:0] A_TH  = 32'h4000_0000;
  localparam logic [31:0] A_TL  = 32'h4000_0004;
  localparam logic [31:0] A_TC  = 32'h4000_0008;
  localparam logic [31:0] A_UNM = 32'h4000_000C;
  localparam logic [31:0] A_ST  = 32'h4000_0014;
  localparam logic [31:0] A_OUT = 32'h1000_0000;

  logic clk;
  logic reset;
  logic irq1, irq4;

  mmio_timer_if b1 ();
  mmio_timer_if b4 ();

  mmio_timer #(.BASE_ADDR(32'h4000_0000), .PRESCALE(1)) dut1 (
    .clk(clk), .reset(reset), .bus(b1), .irq(irq1));
  mmio_timer #(.BASE_ADDR(32'h4000_0000), .PRESCALE(4)) dut4 (
    .clk(clk), .reset(reset), .bus(b4), .irq(irq4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          d;
    logic [31:0] rdata;
    logic        hit;
    logic        irq;
    string       name;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string n, input string f, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %h expected %h", n, f, act, exp);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    if (b1.mem_read || b4.mem_read) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard: read with no expectation queued, got 1 expected 0");
      end else begin
        exp_t it;
        it = sb.pop_front();
        if (it.d == 1) begin
          chk(it.name, "rdata", b1.rdata, it.rdata);
          chk(it.name, "hit", {31'd0, b1.hit}, {31'd0, it.hit});
          chk(it.name, "irq", {31'd0, irq1}, {31'd0, it.irq});
        end else begin
          chk(it.name, "rdata", b4.rdata, it.rdata);
          chk(it.name, "hit", {31'd0, b4.hit}, {31'd0, it.hit});
          chk(it.name, "irq", {31'd0, irq4}, {31'd0, it.irq});
        end
      end
    end
  end

  task automatic clr();
    b1.addr = '0; b1.wdata = '0; b1.mem_read = 1'b0; b1.mem_write = 1'b0;
    b4.addr = '0; b4.wdata = '0; b4.mem_read = 1'b0; b4.mem_write = 1'b0;
  endtask

  // one bus cycle; entered and left at posedge+1
  task automatic cyc(input int d, input logic r, input logic w, input logic [31:0] a, input logic [31:0] wd);
    if (d == 1) begin
      b1.addr = a; b1.wdata = wd; b1.mem_read = r; b1.mem_write = w;
    end else begin
      b4.addr = a; b4.wdata = wd; b4.mem_read = r; b4.mem_write = w;
    end
    @(posedge clk); #1;
    clr();
  endtask

  task automatic wr(input int d, input logic [31:0] a, input logic [31:0] v);
    cyc(d, 1'b0, 1'b1, a, v);
  endtask

  task automatic rd(input int d, input logic [31:0] a, input logic [31:0] e, input logic eh,
                    input logic ei, input string n);
    exp_t it;
    it.d = d; it.rdata = e; it.hit = eh; it.irq = ei; it.name = n;
    sb.push_back(it);
    cyc(d, 1'b1, 1'b0, a, 32'h0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // reset state and decode
    rd(1, A_TH, 32'h0, 1, 0, "rst_th");
    rd(1, A_TL, 32'h0, 1, 0, "rst_tl");
    rd(1, A_TC, 32'h0, 1, 0, "rst_tcon");
    rd(1, A_OUT, 32'h0, 0, 0, "miss");
    rd(1, A_UNM, 32'h0, 1, 0, "unmapped");

    // PRESCALE=1 overflow with IE=1
    wr(1, A_TH, 32'hFFFF_FFF0);
    wr(1, A_TL, 32'hFFFF_FFFE);
    wr(1, A_TC, 32'h3);
    rd(1, A_TL, 32'hFFFF_FFFE, 1, 0, "p1_tl0");
    rd(1, A_TL, 32'hFFFF_FFFF, 1, 0, "p1_tl1");
    rd(1, A_TL, 32'hFFFF_FFF0, 1, 0, "p1_reload");
    rd(1, A_TC, 32'h7, 1, 1, "p1_if_irq");
    wr(1, A_TC, 32'h0);
    rd(1, A_TC, 32'h0, 1, 1, "p1_off_irq_lag");
    rd(1, A_TC, 32'h0, 1, 0, "p1_off_irq_low");

    // IE=0 overflow, then IE=1
    wr(1, A_TH, 32'h55);
    wr(1, A_TL, 32'hFFFF_FFFF);
    wr(1, A_TC, 32'h1);
    rd(1, A_TL, 32'hFFFF_FFFF, 1, 0, "ie0_pre");
    rd(1, A_TL, 32'h55, 1, 0, "ie0_reload");
    rd(1, A_TC, 32'h1, 1, 0, "ie0_if_clear");
    wr(1, A_TC, 32'h3);
    wr(1, A_TL, 32'hFFFF_FFFF);
    rd(1, A_TC, 32'h3, 1, 0, "ie1_wait");
    rd(1, A_TC, 32'h7, 1, 0, "ie1_if");
    rd(1, A_TC, 32'h7, 1, 1, "ie1_irq");

    // clear race with IF already set
    wr(1, A_TL, 32'hFFFF_FFFF);
    wr(1, A_TC, 32'h3);
    rd(1, A_TC, 32'h7, 1, 1, "race1");
    wr(1, A_TC, 32'h3);
    rd(1, A_TC, 32'h3, 1, 1, "clear_lag");
    rd(1, A_TC, 32'h3, 1, 0, "clear_irq_low");
    // clear race with IF clear beforehand: overflow must win
    wr(1, A_TL, 32'hFFFF_FFFF);
    wr(1, A_TC, 32'h3);
    rd(1, A_TC, 32'h7, 1, 0, "race2");
    wr(1, A_TC, 32'h0);
    idle(1);

    // TH write during overflow reloads the old TH
    wr(1, A_TL, 32'hFFFF_FFFF);
    wr(1, A_TC, 32'h1);
    wr(1, A_TH, 32'h99);
    rd(1, A_TL, 32'h55, 1, 0, "th_race_tl");
    wr(1, A_TC, 32'h0);
    rd(1, A_TH, 32'h99, 1, 0, "th_race_th");

    // simultaneous read+write shows pre-write value
    begin
      exp_t it;
      it.d = 1; it.rdata = 32'h99; it.hit = 1'b1; it.irq = 1'b0; it.name = "rdwr";
      sb.push_back(it);
      cyc(1, 1'b1, 1'b1, A_TH, 32'hAB);
    end
    rd(1, A_TH, 32'hAB, 1, 0, "rdwr_after");
    rd(1, 32'h4000_0003, 32'hAB, 1, 0, "byte_lanes");
    wr(1, A_OUT, 32'h1);
    wr(1, A_UNM, 32'hFF);
    wr(1, A_TC, 32'hFFFF_FFF8);
    rd(1, A_TH, 32'hAB, 1, 0, "miss_write");
    rd(1, A_UNM, 32'h0, 1, 0, "unmapped_write");
    rd(1, A_TC, 32'h0, 1, 0, "tcon_upper");

    // PRESCALE=4
    wr(4, A_TL, 32'h0);
    wr(4, A_TC, 32'h1);
    idle(3);
    rd(4, A_TL, 32'h0, 1, 0, "p4_c3");
    rd(4, A_TL, 32'h1, 1, 0, "p4_c4");
    idle(5);
    rd(4, A_TL, 32'h2, 1, 0, "p4_c10");
    wr(4, A_TC, 32'h0);
    idle(10);
    rd(4, A_TL, 32'h3, 1, 0, "p4_hold");
    wr(4, A_TC, 32'h1);
    idle(3);
    rd(4, A_TL, 32'h3, 1, 0, "p4_re3");
    rd(4, A_TL, 32'h4, 1, 0, "p4_re4");
    idle(2);
    wr(4, A_TL, 32'h1234);
    rd(4, A_TL, 32'h1234, 1, 0, "tl_write_wins");
    wr(4, A_TC, 32'h0);

    // mid-operation reset beats a bus write
    reset = 1'b1;
    wr(1, A_TH, 32'h77);
    reset = 1'b0;
    idle(100);
`ifdef MMIO_TIMER_SYSTICK_EN
    rd(1, A_ST, 32'd100, 1, 0, "systick");
`else
    rd(1, A_ST, 32'd0, 1, 0, "systick_off");
`endif
    rd(1, A_TH, 32'h0, 1, 0, "mrst_th");
    rd(1, A_TL, 32'h0, 1, 0, "mrst_tl");
    rd(1, A_TC, 32'h0, 1, 0, "mrst_tcon");
    rd(4, A_TL, 32'h0, 1, 0, "mrst_tl4");

    idle(2);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_timer.md
Name: mmio_timer

Overview:
- Memory-mapped timer peripheral on the CPU's data-memory bus, downstream of the core's load/store path.
- The core's address, write data and MemRead/MemWrite strobes are decoded against a peripheral window next to InstAndDataMemory; returned read data is muxed into the core's Mem_data path.
- Provides a reloadable up-counter with interrupt request and an optional free-running cycle counter (systick).

Parameters:
- BASE_ADDR, 32'h4000_0000, byte address of the first register; the 32-byte window is BASE_ADDR..BASE_ADDR+0x1F.
- PRESCALE, 1, TL advances once every PRESCALE clk cycles while enabled; legal range 1..65535.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- addr  input  32  byte address from the core (ALUOut when IorD=1).
- wdata  input  32  store data from the core (register B).
- mem_read  input  1  load strobe.
- mem_write  input  1  store strobe.
- hit  output  1  combinational; 1 when addr[31:5]==BASE_ADDR[31:5].
- rdata  output  32  combinational read data.
- irq  output  1  registered interrupt request.

Behaviour:
- Register map, word offsets; addr[1:0] is ignored:
  - 0x00 TH: reload value, R/W.
  - 0x04 TL: counter, R/W.
  - 0x08 TCON: bits [2:0] R/W, upper bits read 0. Bit 0 = EN, bit 1 = IE, bit 2 = IF (interrupt flag).
  - 0x14 SYSTICK: read-only.
  - Any other offset: reads 0, writes ignored.
- Reset values: TH=0, TL=0, TCON=0, prescale counter=0, SYSTICK=0, irq=0. rdata and hit follow their combinational rules.
- Reads:
  - rdata = selected register when mem_read && hit, else 32'h0.
  - Zero latency: value is valid in the same cycle, so it meets the core's same-cycle Mem_data capture.
- Writes: occur on the clk edge when mem_write && hit. Writes with mem_write=0 or hit=0 have no effect.
- Prescaler:
  - When EN=1, the prescale counter counts 0..PRESCALE-1 and wraps; a tick is produced when it is at PRESCALE-1.
  - When EN=0, the prescale counter holds and TL holds.
  - PRESCALE=1 means a tick every enabled cycle.
- Counting: on a tick, if TL != 32'hFFFF_FFFF then TL <= TL+1.
- Overflow: on a tick with TL == 32'hFFFF_FFFF:
  - TL <= TH (reload, no wrap to 0).
  - If IE=1, IF <= 1. If IE=0, IF is unchanged.
- irq: registered; irq <= IE & IF, so it asserts one cycle after IF is set.
- Simultaneous events:
  - A software write to TL in the same cycle as a tick or overflow: the write wins (TL <= wdata).
  - A software write to TH during an overflow: the reload uses the old TH; the new TH is visible next cycle.
  - A TCON write in the same cycle as an overflow that sets IF: EN and IE take wdata[1:0]. IF is set to 1 if the overflow sets it, otherwise IF takes wdata[2]; a set is never lost to a same-cycle clear.
  - Software clears IF by writing TCON with bit 2 = 0.
- Mid-operation reset returns all state to reset values on the next edge, regardless of bus activity.
- Bus: mem_read and mem_write asserted together means the write is performed and rdata shows the pre-write value.

Optional Feature:
- Macro: MMIO_TIMER_SYSTICK_EN.
- Defined: SYSTICK is a 32-bit counter, +1 every clk cycle after reset, wraps 32'hFFFF_FFFF -> 0, unaffected by EN. Writes to 0x14 are ignored.
- Undefined: no counter is instantiated; reads of 0x14 return 0.

Test Plan:
- Reset, then read 0x00/0x04/0x08 with mem_read=1 -> rdata=0 for each; irq=0; hit=1; read addr=0x1000_0000 -> hit=0, rdata=0.
- PRESCALE=1: write TH=0xFFFF_FFF0, TL=0xFFFF_FFFE, TCON=3'b011 -> TL reads 0xFFFF_FFFF after 1 cycle, 0xFFFF_FFF0 after 2; IF=1 in the same cycle as the reload; irq=1 one cycle later.
- IE=0 overflow: TCON=3'b001, TL=0xFFFF_FFFF -> TL reloads TH, IF stays 0, irq stays 0. Then write TCON=3'b011 and TL=0xFFFF_FFFF -> irq rises 2 cycles after the TL write.
- Clear race: IF=1, write TCON=3'b011 in the same cycle as a new overflow -> TCON reads 3'b111. A subsequent write of 3'b011 with no overflow -> IF=0, irq falls next cycle.
- PRESCALE=4: TL=0, EN=1 -> TL=1 after 4 cycles, 3 after 12. Clear EN for 10 cycles -> TL stays 3; re-enable -> TL=4 four cycles later.
- With MMIO_TIMER_SYSTICK_EN, reset then read 0x14 at 100 cycles after reset deasserts -> 100; same-cycle write of 0x1234 to TL during a tick -> TL reads 0x1234.
